// File: rtl/alu_seq8_pkg.sv
// Shared constants, FSM state type and result-assembly helper for the
// nibble-serial 8-bit ALU wrapper.
package alu_seq8_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_SHR;
    endfunction

    function automatic logic is_carry_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Shifts run per nibble, so the bit that crosses the nibble seam is patched in here.
    function automatic logic [2*NIB_W:0] assemble(input logic [2:0]         op,
                                                  input logic [2*NIB_W-1:0] a,
                                                  input logic [NIB_W-1:0]   lo,
                                                  input logic [NIB_W-1:0]   hi,
                                                  input logic               hi_cout);
        logic [2*NIB_W-1:0] r;
        logic               c;
        r = {hi, lo};
        c = 1'b0;
        case (op)
            OP_ADD, OP_SUB: c = hi_cout;
            OP_SHL: begin
                r[4] = r[4] | a[3];
                c    = a[7];
            end
            OP_SHR: begin
                r[3] = r[3] | a[4];
                c    = a[0];
            end
            default: c = 1'b0;
        endcase
        return {c, r};
    endfunction

endpackage

// File: rtl/alu_seq8_if.sv
// Request/response handshake bundle for alu_seq8; slave is the ALU block,
// master is whoever issues operations.
interface alu_seq8_if;
    import alu_seq8_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [2*NIB_W-1:0]   req_a;
    logic [2*NIB_W-1:0]   req_b;
    logic                 req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*NIB_W-1:0]   rsp_o;
    logic                 rsp_cout;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_o, rsp_cout, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_o, rsp_cout, rsp_err
    );

endinterface

// File: rtl/alu_seq8.sv
// 8-bit ALU built by running an external combinational 4-bit ALU twice (low
// then high nibble). Define ALU_SEQ8_SETTLE_EN to give each nibble pass two cycles.
module alu_seq8
    import alu_seq8_pkg::*;
#(
    parameter logic [7:0] ERR_VALUE = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq8_if.slave        bus,
    output logic [2:0]       alu_s,
    output logic [NIB_W-1:0] alu_a,
    output logic [NIB_W-1:0] alu_b,
    output logic             alu_cin,
    input  logic [NIB_W-1:0] alu_o,
    input  logic             alu_cout
);

    state_t             state;
    logic [2:0]         op_q;
    logic [2*NIB_W-1:0] a_q;
    logic [NIB_W-1:0]   b_hi_q;
    logic [NIB_W-1:0]   lo_q;
    logic [NIB_W-1:0]   hi_q;
    logic               hi_cout_q;
    logic               step;

`ifdef ALU_SEQ8_SETTLE_EN
    // Toggles through each nibble pass so capture happens on its second cycle.
    logic settle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= 1'b0;
        end else if (state == LO || state == HI) begin
            settle <= ~settle;
        end else begin
            settle <= 1'b0;
        end
    end

    assign step = settle;
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_hi_q        <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            hi_cout_q     <= 1'b0;
            alu_s         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_cin       <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_o     <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_q          <= bus.req_op;
                        a_q           <= bus.req_a;
                        b_hi_q        <= bus.req_b[2*NIB_W-1:NIB_W];
                        bus.req_ready <= 1'b0;
                        if (is_legal(bus.req_op)) begin
                            state   <= LO;
                            alu_s   <= bus.req_op;
                            alu_a   <= bus.req_a[NIB_W-1:0];
                            alu_b   <= bus.req_b[NIB_W-1:0];
                            alu_cin <= is_carry_op(bus.req_op) ? bus.req_cin : 1'b0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                LO: begin
                    if (step) begin
                        lo_q    <= alu_o;
                        alu_a   <= a_q[2*NIB_W-1:NIB_W];
                        alu_b   <= b_hi_q;
                        alu_cin <= is_carry_op(op_q) ? alu_cout : 1'b0;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (step) begin
                        hi_q      <= alu_o;
                        hi_cout_q <= alu_cout;
                        alu_s     <= '0;
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_cin   <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        if (is_legal(op_q)) begin
                            {bus.rsp_cout, bus.rsp_o} <= assemble(op_q, a_q, lo_q, hi_q, hi_cout_q);
                            bus.rsp_err <= 1'b0;
                        end else begin
                            bus.rsp_o    <= ERR_VALUE;
                            bus.rsp_cout <= 1'b0;
                            bus.rsp_err  <= 1'b1;
                        end
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq8.md
ALU_SEQ8 -- requirements
Module: alu_seq8

Interface
REQ-001 Parameter ERR_VALUE, default 8'h00: value driven on rsp_o for an illegal opcode.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  3  opcode: 0 add, 1 sub, 2 or, 3 and, 4 shl, 5 shr, 6/7 illegal.
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 req_cin  input  1  carry-in (add) or borrow-in (sub).
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_o  output  8  result; rsp_cout  output  1  carry/borrow/shifted-out bit; rsp_err  output  1  illegal opcode.
REQ-012 alu_s  output  3; alu_a, alu_b  output  4; alu_cin  output  1: drive an external combinational 4-bit ALU.
REQ-013 alu_o  input  4; alu_cout  input  1: 4-bit ALU results.

Function
REQ-014 The FSM SHALL have the states IDLE, LO, HI and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 On req_valid&&req_ready, the block SHALL register op/a/b/cin and go to LO (legal op) or RESP (op 6/7).
REQ-016 LO SHALL drive alu_s=op, alu_a=a[3:0], alu_b=b[3:0], alu_cin=cin (op 0/1) else 0, and capture alu_o/alu_cout at the end of the cycle.
REQ-017 HI SHALL drive a[7:4], b[7:4], alu_cin = the captured LO alu_cout (op 0/1) else 0, and capture alu_o/alu_cout.
REQ-018 Add/sub: rsp_o = {hi,lo}, rsp_cout = HI alu_cout (borrow for sub); or/and: rsp_cout=0.
REQ-019 Shl: rsp_o[4] SHALL be OR-ed with a[3], rsp_cout=a[7]; shr: rsp_o[3] SHALL be OR-ed with a[4], rsp_cout=a[0]; ALU cout SHALL be ignored for op 2-5.
REQ-020 Illegal op: rsp_o=ERR_VALUE, rsp_cout=0, rsp_err=1, and no ALU pass.
REQ-021 Latency: rsp_valid SHALL rise 3 cycles after the accept edge for legal ops and 1 cycle after it for illegal ops.
REQ-022 In RESP, rsp_valid=1 and rsp_o/rsp_cout/rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then go to IDLE; there is no request/response overlap.
REQ-023 Outside LO/HI, alu_s/alu_a/alu_b/alu_cin SHALL be 0.
REQ-024 req_* changes outside the accept edge SHALL have no effect.

Reset
REQ-025 rst SHALL immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_o=0, rsp_cout=0, rsp_err=0, and alu_* outputs to 0.
REQ-026 Reset mid-operation (LO/HI/RESP) SHALL discard the operation with no response.

Configuration
REQ-027 With ALU_SEQ8_SETTLE_EN defined, LO and HI SHALL each last 2 cycles with capture on the second one, giving a legal-op latency of 5; without it, each lasts 1 cycle (latency 3).
REQ-028 Illegal-op latency and all other behaviour SHALL be identical with and without ALU_SEQ8_SETTLE_EN.

Structure
REQ-029 The package alu_seq8_pkg SHALL hold the opcode constants (OP_ADD..OP_SHR), the state enum and the nibble width.
REQ-030 No sub-module; the 4-bit ALU SHALL be external and connected at the parent level.

Verification (behavioural 4-bit ALU model attached to alu_*)
REQ-031 add a=8'h3A b=8'h47 cin=0 -> rsp_o=8'h81, rsp_cout=0, rsp_valid 3 cycles after accept.
REQ-032 sub a=8'h00 b=8'h01 cin=0 -> rsp_o=8'hFF, rsp_cout=1; sub 8'h10-8'h01 -> 8'h0F, rsp_cout=0.
REQ-033 shl a=8'h96 -> 8'h2C, rsp_cout=1; shr a=8'h96 -> 8'h4B, rsp_cout=0.
REQ-034 op=7 -> rsp_o=ERR_VALUE, rsp_err=1 one cycle after accept, alu_* remain 0.
REQ-035 rsp_ready held 0 for 4 cycles -> rsp_* stable and req_ready=0; rsp_ready=1 -> req_ready=1 on the next cycle.
REQ-036 rst asserted in HI -> rsp_valid never rises, and a following add 8'h01+8'h01 -> 8'h02.
